demux2x32_buf: RTL and testbench
================================

# demux2x32_buf

Buffered 1-to-2 demultiplexer for 32-bit words: the inverse of the 2:1 word multiplexer. A single producer offers a word plus a select bit. The block steers the word into one of two independent output FIFOs, each drained by its own consumer through a valid/ready handshake. It sits between a single result source (e.g. an execute/write-back stage) and two destination paths, and isolates them so a stalled consumer never blocks the other.

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, ≥ 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- s  input  1  route select for the offered word; 0 → y0, 1 → y1.
- a  input  WIDTH  offered data word.
- a_valid  input  1  producer offers a/s this cycle.
- a_ready  output  1  block accepts the offered word this cycle.
- y0  output  WIDTH  head word of FIFO 0.
- y0_valid  output  1  FIFO 0 non-empty.
- y0_ready  input  1  consumer 0 takes y0 this cycle.
- y1, y1_valid, y1_ready  same as y0 group, for FIFO 1.
- cnt0  output  AW+1  occupancy of FIFO 0 (0..DEPTH).
- cnt1  output  AW+1  occupancy of FIFO 1 (0..DEPTH).

## Operation
- Two identical circular FIFOs k∈{0,1}, each with DEPTH×WIDTH storage, write pointer, read pointer (AW bits, wrap modulo DEPTH) and an occupancy counter (AW+1 bits).
- a_ready = ~full[s] (combinational from s and registered occupancy); full[k] = (cntk == DEPTH). No dependence on y0_ready/y1_ready.
- Push: a_valid & a_ready → a written at wptr[s], wptr[s] += 1. Only FIFO s changes.
- Pop k: yk_valid & yk_ready → rptr[k] += 1. yk_ready while yk_valid=0 is ignored.
- yk = storage[rptr[k]]; yk_valid = (cntk != 0).
- Occupancy per FIFO: push only +1, pop only −1, push and pop same cycle unchanged.
- Pushes and pops on different FIFOs are independent and may all occur in one cycle.
- Order is preserved within each FIFO. There is no ordering relation between y0 and y1.
- No bypass: a word never appears on yk in its acceptance cycle.
- a_valid while a_ready=0: nothing stored; the producer must hold a/s/a_valid stable until accepted.

## Timing
- Reset (async, on rst high, held while high): all pointers 0, cnt0=cnt1=0, storage 0. Hence y0=y1=0, y0_valid=y1_valid=0, a_ready=1.
- Latency: word accepted at edge N is visible on yk with yk_valid=1 after edge N (cycle N+1) if FIFO k was empty. Otherwise it appears after all earlier words of FIFO k are popped.
- Throughput: one push per cycle, plus one pop per FIFO per cycle.
- Full FIFO k with pop and push to k in the same cycle: push refused, because a_ready was 0 at cycle start. Occupancy becomes DEPTH−1 and a_ready rises the next cycle.
- Empty FIFO with push and yk_ready=1 same cycle: no pop (yk_valid=0). The word waits one cycle.
- Pointer wrap: after DEPTH pushes, wptr returns to 0. Data integrity holds across any number of wraps.
- rst asserted mid-operation: all buffered words discarded immediately, outputs return to reset values without waiting for a clock edge.

## Test plan
- Reset: hold rst=1 with a_valid=1, s=0, a=32'hDEAD_BEEF → y0_valid=y1_valid=0, y0=y1=0, cnt0=cnt1=0, a_ready=1. After release, the first edge with a_valid=1 stores DEAD_BEEF.
- Steering: push 32'h0000_0000 (s=0), 32'hFFFF_FFFF (s=1), 32'h1234_5678 (s=0), with both readys held 0. Expected: y0=0000_0000, cnt0=2; y1=FFFF_FFFF, cnt1=1. Then pulse y0_ready → y0=1234_5678.
- No head-of-line blocking: fill FIFO 0 (DEPTH words, y0_ready=0). Expected: a_ready=0 with s=0 and a_ready=1 with s=1. A push to y1 succeeds while FIFO 0 stays full and unchanged.
- Simultaneous events:
  - FIFO 1 at cnt1=1: push to s=1 and pop y1 in the same cycle → cnt1 stays 1, y1 advances to the new word.
  - FIFO 0 full: push to s=0 and pop in the same cycle → push refused, cnt0=DEPTH−1.
- Wrap and order: stream 4·DEPTH+1 incrementing words (1,2,3,…) with alternating s and random yk_ready. Expected: y0 delivers the odd sequence and y1 the even sequence, each exactly in order with no loss or duplication. Counters never exceed DEPTH.
- Reset mid-stream: with cnt0=2 and cnt1=1, assert rst between edges → y0_valid/y1_valid fall immediately, cnt0=cnt1=0, and no stale word is output after release.

Source files
------------

// File: rtl/demux2x32_buf.sv
// demux2x32_buf: steers each offered word into one of two valid/ready output FIFOs by select bit s.
module demux2x32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [AW:0]      cnt0,
    output logic [AW:0]      cnt1
);
    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [AW-1:0]    wptr [2];
    logic [AW-1:0]    rptr [2];
    logic [AW:0]      cnt [2];
    logic [1:0]       full, push, pop;
    // a_ready looks only at the selected FIFO, so a stalled consumer never blocks the other path
    assign full     = {cnt[1] == (AW+1)'(DEPTH), cnt[0] == (AW+1)'(DEPTH)};
    assign a_ready  = ~full[s];
    assign push     = {a_valid & a_ready & s, a_valid & a_ready & ~s};
    assign pop      = {y1_ready & y1_valid, y0_ready & y0_valid};
    assign y0       = mem[0][rptr[0]];
    assign y1       = mem[1][rptr[1]];
    assign y0_valid = cnt[0] != '0;
    assign y1_valid = cnt[1] != '0;
    assign cnt0     = cnt[0];
    assign cnt1     = cnt[1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
                cnt[k]  <= '0;
                for (int i = 0; i < DEPTH; i++) mem[k][i] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem[k][wptr[k]] <= a;
                    wptr[k]         <= wptr[k] + 1'b1;
                end
                if (pop[k]) rptr[k] <= rptr[k] + 1'b1;
                if (push[k] != pop[k]) cnt[k] <= push[k] ? cnt[k] + 1'b1 : cnt[k] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_demux2x32_buf.sv
// tb_demux2x32_buf: scoreboard bench with a queue-based model of two bounded FIFOs.
module tb_demux2x32_buf;
    localparam int DEPTH = 2;
    logic        clk, rst, s, a_valid, a_ready;
    logic [31:0] a, y0, y1;
    logic        y0_valid, y0_ready, y1_valid, y1_ready;
    logic [1:0]  cnt0, cnt1;
    int          checks = 0, errors = 0;
    int          occ0 = 0, occ1 = 0;
    logic [31:0] exp0[$], exp1[$], got0[$], got1[$];

    demux2x32_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s(s), .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
        .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: each FIFO is a bounded queue; the scoreboard queue holds words in flight
    always @(posedge clk or posedge rst) begin
        bit p0, p1, q0, q1;
        if (rst) begin
            occ0 <= 0;
            occ1 <= 0;
            exp0.delete();
            exp1.delete();
        end else begin
            p0 = a_valid && !s && occ0 < DEPTH;
            p1 = a_valid && s && occ1 < DEPTH;
            q0 = y0_ready && occ0 > 0;
            q1 = y1_ready && occ1 > 0;
            if (p0) exp0.push_back(a);
            if (p1) exp1.push_back(a);
            occ0 <= occ0 + int'(p0) - int'(q0);
            occ1 <= occ1 + int'(p1) - int'(q1);
        end
    end

    // Monitor: compares flags and pops the scoreboard whenever a consumer takes a word
    always @(negedge clk) begin
        if (!rst) begin
            check("a_ready", 32'(a_ready), 32'((s ? occ1 : occ0) < DEPTH));
            check("y0_valid", 32'(y0_valid), 32'(occ0 > 0));
            check("y1_valid", 32'(y1_valid), 32'(occ1 > 0));
            check("cnt0", 32'(cnt0), 32'(occ0));
            check("cnt1", 32'(cnt1), 32'(occ1));
            if (y0_valid && y0_ready) begin
                if (exp0.size() == 0) check("y0_unexpected", y0, 32'hx);
                else check("y0_data", y0, exp0.pop_front());
                got0.push_back(y0);
            end
            if (y1_valid && y1_ready) begin
                if (exp1.size() == 0) check("y1_unexpected", y1, 32'hx);
                else check("y1_data", y1, exp1.pop_front());
                got1.push_back(y1);
            end
        end
    end

    task automatic drive(bit av, bit sel, logic [31:0] d, bit r0, bit r1);
        a_valid = av; s = sel; a = d; y0_ready = r0; y1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (occ0 > 0 || occ1 > 0); i++) drive(0, 0, 0, 1, 1);
        check("drained0", 32'(cnt0), 0);
        check("drained1", 32'(cnt1), 0);
    endtask

    initial begin
        bit pend, acc;
        int nxt, budget;
        logic [31:0] want;
        rst = 1; a_valid = 1; s = 0; a = 32'hDEAD_BEEF; y0_ready = 0; y1_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y0_valid", 32'(y0_valid), 0);
        check("rst_y1_valid", 32'(y1_valid), 0);
        check("rst_y0", y0, 0);
        check("rst_y1", y1, 0);
        check("rst_cnt0", 32'(cnt0), 0);
        check("rst_cnt1", 32'(cnt1), 0);
        check("rst_a_ready", 32'(a_ready), 1);
        rst = 0;
        drive(1, 0, 32'hDEAD_BEEF, 0, 0);
        check("first_word", y0, 32'hDEAD_BEEF);
        drain();
        // Steering
        drive(1, 0, 32'h0000_0000, 0, 0);
        drive(1, 1, 32'hFFFF_FFFF, 0, 0);
        drive(1, 0, 32'h1234_5678, 0, 0);
        check("steer_y0", y0, 32'h0000_0000);
        check("steer_cnt0", 32'(cnt0), 2);
        check("steer_y1", y1, 32'hFFFF_FFFF);
        check("steer_cnt1", 32'(cnt1), 1);
        drive(0, 0, 0, 1, 0);
        check("steer_pop_y0", y0, 32'h1234_5678);
        // Push and pop FIFO 1 together at occupancy 1
        drive(1, 1, 32'hAAAA_5555, 0, 1);
        check("pushpop_cnt1", 32'(cnt1), 1);
        check("pushpop_y1", y1, 32'hAAAA_5555);
        // No head-of-line blocking with FIFO 0 full
        drive(1, 0, 32'h0000_00C0, 0, 0);
        a_valid = 0; s = 0; #1;
        check("full_ready_s0", 32'(a_ready), 0);
        s = 1; #1;
        check("full_ready_s1", 32'(a_ready), 1);
        drive(1, 1, 32'h0000_00B1, 0, 0);
        check("hol_cnt1", 32'(cnt1), 2);
        check("hol_cnt0", 32'(cnt0), DEPTH);
        check("hol_y0", y0, 32'h1234_5678);
        // Full FIFO 0 with push and pop in the same cycle: push refused
        drive(1, 0, 32'h0000_00C1, 1, 0);
        check("fullpp_cnt0", 32'(cnt0), DEPTH - 1);
        check("fullpp_y0", y0, 32'h0000_00C0);
        check("fullpp_ready", 32'(a_ready), 1);
        drive(1, 0, 32'h0000_00C1, 0, 0);
        drain();
        // Wrap and order: 4*DEPTH+1 incrementing words, odd to y0, even to y1
        got0.delete(); got1.delete();
        nxt = 1; budget = 0;
        while (nxt <= 4 * DEPTH + 1 && budget < 300) begin
            a_valid = 1; s = (nxt % 2 == 0); a = 32'(nxt);
            y0_ready = 1'($urandom); y1_ready = 1'($urandom);
            #1 acc = a_ready;
            @(posedge clk);
            #1;
            if (acc) nxt++;
            budget++;
        end
        check("wrap_budget", 32'(budget < 300), 1);
        drain();
        check("wrap_got0_n", got0.size(), 2 * DEPTH + 1);
        check("wrap_got1_n", got1.size(), 2 * DEPTH);
        for (int i = 0; i < got0.size(); i++) check("wrap_odd", got0[i], 32'(2 * i + 1));
        for (int i = 0; i < got1.size(); i++) check("wrap_even", got1[i], 32'(2 * i + 2));
        // Random traffic with the producer holding its offer until accepted
        pend = 0; want = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(3) != 0) begin
                pend = 1; s = 1'($urandom); want = $urandom;
            end
            a_valid = pend; a = want;
            y0_ready = ($urandom_range(2) != 0); y1_ready = ($urandom_range(3) == 0);
            #1 acc = a_valid && a_ready;
            @(posedge clk);
            #1;
            if (acc) pend = 0;
        end
        drain();
        // Reset mid-stream
        drive(1, 0, 32'h0000_0A01, 0, 0);
        drive(1, 0, 32'h0000_0A02, 0, 0);
        drive(1, 1, 32'h0000_0B01, 0, 0);
        check("pre_rst_cnt0", 32'(cnt0), 2);
        check("pre_rst_cnt1", 32'(cnt1), 1);
        a_valid = 0;
        #2 rst = 1;
        #1;
        check("midrst_y0_valid", 32'(y0_valid), 0);
        check("midrst_y1_valid", 32'(y1_valid), 0);
        check("midrst_cnt0", 32'(cnt0), 0);
        check("midrst_cnt1", 32'(cnt1), 0);
        check("midrst_a_ready", 32'(a_ready), 1);
        drive(0, 0, 0, 1, 1);
        rst = 0;
        repeat (4) drive(0, 0, 0, 1, 1);
        check("post_rst_y0_valid", 32'(y0_valid), 0);
        check("post_rst_y1_valid", 32'(y1_valid), 0);
        check("post_rst_stale0", exp0.size(), 0);
        check("post_rst_stale1", exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
